// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and helpers for the
// pointer-based FIFO read and write controllers.
package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [PTR_W-1:0] ptr_t;

  // Occupancy between two extended pointers, modulo 2**PTR_W.
  function automatic ptr_t ptr_dist(
    input ptr_t a,
    input ptr_t b
  );
    return a - b;
  endfunction

  function automatic logic ptr_empty(
    input ptr_t a,
    input ptr_t b
  );
    return a == b;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer (head + skid) with
// occupancy count; head drives the output word.
module fifo_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] skid;
  logic              pop;
  logic              push;

  assign pop       = out_valid & out_ready;
  assign push      = in_valid;
  assign out_valid = (occ != 2'd0);
  assign out_data  = head;

  // Upstream never pushes into a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (pop && occ == 2'd2) begin
      head <= skid;
      if (push)
        skid <= in_data;
      else
        occ <= 2'd1;
    end else if (pop) begin
      if (push)
        head <= in_data;
      else
        occ <= 2'd0;
    end else if (push && occ == 2'd0) begin
      head <= in_data;
      occ  <= 2'd1;
    end else if (push) begin
      skid <= in_data;
      occ  <= 2'd2;
    end
  end

endmodule

// File: rtl/fifo_rd_port.sv
// FIFO read-side controller: owns rd_ptr, issues RAM reads
// and presents a first-word-fall-through stream.
module fifo_rd_port #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 3,
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              empty,
  output logic              ptr_err
);

  import fifo_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic       ram_empty;
  logic       pop;
  logic       inflight;
  logic [1:0] occ;
  logic [1:0] cnt;

  assign ram_empty = ptr_empty(wr_ptr, rd_ptr);
  assign pop       = m_valid & m_ready;
  assign cnt       = occ + {1'b0, inflight};
  assign mem_raddr = rd_ptr[ADDR_W-1:0];
  assign empty     = ram_empty & (cnt == 2'd0);

  // Never more than two words outstanding past the RAM.
  assign mem_ren = !ram_empty & ((cnt < 2'd2) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      ptr_err  <= 1'b0;
    end else begin
      if (mem_ren)
        rd_ptr <= rd_ptr + PTR_W'(1);
      inflight <= mem_ren;
      if (ptr_dist(wr_ptr, rd_ptr) > PTR_W'(DEPTH))
        ptr_err <= 1'b1;
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (mem_rdata),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .occ       (occ)
  );

endmodule
